noekeon_chain_ctrl: RTL and testbench

//  Sequencer in front of one Noekeon core. Loads the key and runs a stream of 128-bit blocks

---
 rtl/noekeon_pkg.sv | 26 ++
 rtl/noekeon_chain_ctrl_if.sv | 31 +++
 rtl/noekeon_chain_reg.sv | 36 +++
 rtl/noekeon_chain_ctrl.sv | 161 ++++++++++++++++
 tb/tb_noekeon_chain_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noekeon_pkg.sv
// Shared widths, state encoding and reference vectors for the Noekeon chaining controller.
package noekeon_pkg;

  localparam int unsigned W = 128;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_KEY_WR   = 3'd1;
  localparam logic [2:0] ST_KEY_WAIT = 3'd2;
  localparam logic [2:0] ST_BLK_WR   = 3'd3;
  localparam logic [2:0] ST_BLK_WAIT = 3'd4;
  localparam logic [2:0] ST_RESULT   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_KEY_WR   = ST_KEY_WR,
    S_KEY_WAIT = ST_KEY_WAIT,
    S_BLK_WR   = ST_BLK_WR,
    S_BLK_WAIT = ST_BLK_WAIT,
    S_RESULT   = ST_RESULT
  } ctrlStateT;

  // All-zero key, all-zero plaintext, encipher: direct and indirect key mode.
  localparam logic [W-1:0] TV_DIRECT_CT   = 128'h503D2DFC24B70148699E29FAB1656851;
  localparam logic [W-1:0] TV_INDIRECT_CT = 128'hF678178B99A99F089299C716BA693381;

endpackage

// File: rtl/noekeon_chain_ctrl_if.sv
// Block-in / result-out stream between the bus-side FIFO and the chaining controller.
interface noekeon_chain_ctrl_if
  import noekeon_pkg::*;
();

  logic         inBlkValid;
  logic [W-1:0] inBlk;
  logic         outBlkReady;
  logic         outResValid;
  logic [W-1:0] outRes;
  logic         inResReady;

  modport slave (
    input  inBlkValid,
    input  inBlk,
    output outBlkReady,
    output outResValid,
    output outRes,
    input  inResReady
  );

  modport master (
    output inBlkValid,
    output inBlk,
    input  outBlkReady,
    input  outResValid,
    input  outRes,
    output inResReady
  );

endinterface

// File: rtl/noekeon_chain_reg.sv
// CBC chaining value: IV load, write-side xor, result-side xor and post-block update.
module noekeon_chain_reg
  import noekeon_pkg::*;
(
  input  logic         inClk,
  input  logic         inReset,
  input  logic         inLoad,
  input  logic [W-1:0] inLoadVal,
  input  logic         inXorSel,
  input  logic [W-1:0] inBlk,
  output logic [W-1:0] outWrData_c,
  input  logic         inUpdate,
  input  logic         inUpdSel,
  input  logic [W-1:0] inCoreData,
  input  logic [W-1:0] inSavedBlk,
  input  logic         inResXor,
  output logic [W-1:0] outRes_c
);

  logic [W-1:0] chain;

  // Chain register: IV load wins over a block update; decipher chains on the ciphertext.
  always_ff @(posedge inClk) begin
    if (inReset) begin
      chain <= '0;
    end else if (inLoad) begin
      chain <= inLoadVal;
    end else if (inUpdate) begin
      chain <= inUpdSel ? inSavedBlk : inCoreData;
    end
  end

  assign outWrData_c = inXorSel ? (inBlk ^ chain) : inBlk;
  assign outRes_c    = inResXor ? (inCoreData ^ chain) : inCoreData;

endmodule

// File: rtl/noekeon_chain_ctrl.sv
// Sequencer in front of one Noekeon core: key load, ECB/CBC block stream, busy handshake.
module noekeon_chain_ctrl
  import noekeon_pkg::*;
#(
  parameter int unsigned BUSY_TMO = 64,
  parameter int unsigned BUSY_ARM = 1
) (
  input  logic                inClk,
  input  logic                inReset,
  input  logic                inCfgCbc,
  input  logic                inCfgDecipher,
  input  logic                inCfgIndirect,
  input  logic                inKeyLoad,
  input  logic [W-1:0]        inKey,
  input  logic                inIvLoad,
  input  logic [W-1:0]        inIv,
  noekeon_chain_ctrl_if.slave bus,
  output logic                outCtrlBusy,
  output logic                outErr,
  output logic                outCoreMode,
  output logic                outCoreDecipher,
  output logic                outCoreKeyWr,
  output logic [W-1:0]        outCoreKeyData,
  output logic                outCoreDataWr,
  output logic [W-1:0]        outCoreDataData,
  input  logic                inCoreBusy,
  input  logic [W-1:0]        inCoreData
);

  localparam int unsigned ARM_W = (BUSY_ARM > 1) ? $clog2(BUSY_ARM) : 1;
  localparam int unsigned TMO_W = $clog2(BUSY_TMO + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(BUSY_ARM - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  ctrlStateT        state;
  logic             keyValid;
  logic             cbcQ;
  logic             decQ;
  logic [W-1:0]     blkQ;
  logic [ARM_W-1:0] armCnt;
  logic [TMO_W-1:0] tmoCnt;

  logic             acceptC;
  logic             ivLoadC;
  logic             chainUpdC;
  logic [W-1:0]     wrDataC;
  logic [W-1:0]     resC;

  // Blocks are only taken in IDLE with a valid key and no higher-priority request pending.
  assign bus.outBlkReady = keyValid & (state == S_IDLE) & ~inKeyLoad & ~inIvLoad;
  assign acceptC         = bus.outBlkReady & bus.inBlkValid;
  assign ivLoadC         = (state == S_IDLE) & ~inKeyLoad & inIvLoad;
  assign chainUpdC       = (state == S_BLK_WAIT) & ~inCoreBusy & cbcQ;

  noekeon_chain_reg uChain (
    .inClk       (inClk),
    .inReset     (inReset),
    .inLoad      (ivLoadC),
    .inLoadVal   (inIv),
    .inXorSel    (inCfgCbc & ~inCfgDecipher),
    .inBlk       (bus.inBlk),
    .outWrData_c (wrDataC),
    .inUpdate    (chainUpdC),
    .inUpdSel    (decQ),
    .inCoreData  (inCoreData),
    .inSavedBlk  (blkQ),
    .inResXor    (cbcQ & decQ),
    .outRes_c    (resC)
  );

  // Controller FSM with registered core strobes, result stream and status.
  always_ff @(posedge inClk) begin
    if (inReset) begin
      state           <= S_IDLE;
      keyValid        <= 1'b0;
      cbcQ            <= 1'b0;
      decQ            <= 1'b0;
      blkQ            <= '0;
      armCnt          <= '0;
      tmoCnt          <= '0;
      bus.outResValid <= 1'b0;
      bus.outRes      <= '0;
      outCtrlBusy     <= 1'b0;
      outErr          <= 1'b0;
      outCoreMode     <= 1'b0;
      outCoreDecipher <= 1'b0;
      outCoreKeyWr    <= 1'b0;
      outCoreKeyData  <= '0;
      outCoreDataWr   <= 1'b0;
      outCoreDataData <= '0;
    end else begin
      outCoreKeyWr  <= 1'b0;
      outCoreDataWr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inKeyLoad) begin
            outCoreKeyData  <= inKey;
            outCoreMode     <= inCfgIndirect;
            outCoreDecipher <= inCfgDecipher;
            outCoreKeyWr    <= 1'b1;
            keyValid        <= 1'b0;
            outErr          <= 1'b0;
            armCnt          <= '0;
            outCtrlBusy     <= 1'b1;
            state           <= S_KEY_WR;
          end else if (acceptC) begin
            blkQ            <= bus.inBlk;
            cbcQ            <= inCfgCbc;
            decQ            <= inCfgDecipher;
            outCoreDecipher <= inCfgDecipher;
            outCoreDataData <= wrDataC;
            outCoreDataWr   <= 1'b1;
            armCnt          <= '0;
            outCtrlBusy     <= 1'b1;
            state           <= S_BLK_WR;
          end
        end
        S_KEY_WR, S_BLK_WR: begin
          if (armCnt == ARM_LAST) begin
            tmoCnt <= '0;
            state  <= (state == S_KEY_WR) ? S_KEY_WAIT : S_BLK_WAIT;
          end else begin
            armCnt <= armCnt + ARM_W'(1);
          end
        end
        S_KEY_WAIT, S_BLK_WAIT: begin
          if (!inCoreBusy) begin
            if (state == S_KEY_WAIT) begin
              keyValid    <= 1'b1;
              outCtrlBusy <= 1'b0;
              state       <= S_IDLE;
            end else begin
              bus.outRes      <= resC;
              bus.outResValid <= 1'b1;
              state           <= S_RESULT;
            end
          end else if (tmoCnt == TMO_LAST) begin
            outErr      <= 1'b1;
            keyValid    <= 1'b0;
            outCtrlBusy <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tmoCnt <= tmoCnt + TMO_W'(1);
          end
        end
        S_RESULT: begin
          if (bus.inResReady) begin
            bus.outResValid <= 1'b0;
            outCtrlBusy     <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: begin
          outCtrlBusy <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noekeon_chain_ctrl.sv
// Directed bench for noekeon_chain_ctrl with a behavioural core stand-in.
module tb_noekeon_chain_ctrl;
  import noekeon_pkg::*;

  localparam logic [W-1:0] V1 = 128'h503D2DFC24B70148699E29FAB1656851;
  localparam logic [W-1:0] V3 = 128'hF678178B99A99F089299C716BA693381;

  logic         inClk = 1'b0;
  logic         inReset;
  logic         inCfgCbc, inCfgDecipher, inCfgIndirect;
  logic         inKeyLoad, inIvLoad;
  logic [W-1:0] inKey, inIv;
  logic         outCtrlBusy, outErr, outCoreMode, outCoreDecipher;
  logic         outCoreKeyWr, outCoreDataWr;
  logic [W-1:0] outCoreKeyData, outCoreDataData;
  logic         coreBusy;
  logic [W-1:0] coreData;

  logic         stuckBusy;
  logic [W-1:0] coreKey;
  logic         coreModeQ;
  int unsigned  coreCnt;

  int nTests = 0;
  int nFail  = 0;

  noekeon_chain_ctrl_if bus ();

  noekeon_chain_ctrl #(.BUSY_TMO(64), .BUSY_ARM(1)) dut (
    .inClk           (inClk),
    .inReset         (inReset),
    .inCfgCbc        (inCfgCbc),
    .inCfgDecipher   (inCfgDecipher),
    .inCfgIndirect   (inCfgIndirect),
    .inKeyLoad       (inKeyLoad),
    .inKey           (inKey),
    .inIvLoad        (inIvLoad),
    .inIv            (inIv),
    .bus             (bus),
    .outCtrlBusy     (outCtrlBusy),
    .outErr          (outErr),
    .outCoreMode     (outCoreMode),
    .outCoreDecipher (outCoreDecipher),
    .outCoreKeyWr    (outCoreKeyWr),
    .outCoreKeyData  (outCoreKeyData),
    .outCoreDataWr   (outCoreDataWr),
    .outCoreDataData (outCoreDataData),
    .inCoreBusy      (coreBusy),
    .inCoreData      (coreData)
  );

  always #5 inClk = ~inClk;

  // Core stand-in: known Noekeon vectors for the zero key, otherwise an invertible toy cipher.
  function automatic logic [W-1:0] coreFn(input logic [W-1:0] k, input logic m,
                                          input logic d, input logic [W-1:0] x);
    logic [W-1:0] t;
    if (k == '0 && !m && !d && x == '0) return V1;
    if (k == '0 && !m &&  d && x == V1) return '0;
    if (k == '0 &&  m && !d && x == '0) return V3;
    if (d) return {x[2:0], x[W-1:3]} ^ k;
    t = x ^ k;
    return {t[W-4:0], t[W-1:W-3]};
  endfunction

  // Core stand-in timing: busy for a few cycles after each key or data write.
  always @(posedge inClk) begin
    if (inReset) begin
      coreBusy  <= 1'b0;
      coreCnt   <= 0;
      coreData  <= '0;
      coreKey   <= '0;
      coreModeQ <= 1'b0;
    end else if (stuckBusy) begin
      coreBusy <= 1'b1;
      coreCnt  <= 0;
    end else if (outCoreKeyWr) begin
      coreKey   <= outCoreKeyData;
      coreModeQ <= outCoreMode;
      coreBusy  <= 1'b1;
      coreCnt   <= 2;
    end else if (outCoreDataWr) begin
      coreData <= coreFn(coreKey, coreModeQ, outCoreDecipher, outCoreDataData);
      coreBusy <= 1'b1;
      coreCnt  <= 4;
    end else if (coreCnt != 0) begin
      coreCnt <= coreCnt - 1;
    end else begin
      coreBusy <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic loadKey(input string tag, input logic [W-1:0] key, input logic ind);
    int n;
    inKey = key; inCfgIndirect = ind; inCfgDecipher = 1'b0; inKeyLoad = 1'b1;
    tick();
    inKeyLoad = 1'b0;
    check({tag, " keyWr"}, W'(outCoreKeyWr), W'(1'b1));
    check({tag, " keyData"}, outCoreKeyData, key);
    check({tag, " mode"}, W'(outCoreMode), W'(ind));
    check({tag, " errClr"}, W'(outErr), '0);
    tick();
    check({tag, " keyWrPulse"}, W'(outCoreKeyWr), '0);
    n = 0;
    while (outCtrlBusy && n < 100) begin tick(); n++; end
    check({tag, " keyDone"}, W'(outCtrlBusy), '0);
  endtask

  task automatic loadIv(input logic [W-1:0] v);
    inIv = v; inIvLoad = 1'b1;
    tick();
    inIvLoad = 1'b0;
  endtask

  task automatic runBlk(input string tag, input logic [W-1:0] blk, input logic cbc,
                        input logic dec, output logic [W-1:0] res);
    int n;
    bus.inBlk = blk; inCfgCbc = cbc; inCfgDecipher = dec; bus.inBlkValid = 1'b1;
    #1;
    n = 0;
    while (!bus.outBlkReady && n < 50) begin @(posedge inClk); #1; n++; end
    check({tag, " accept"}, W'(bus.outBlkReady), W'(1'b1));
    tick();
    bus.inBlkValid = 1'b0;
    n = 0;
    while (!bus.outResValid && n < 200) begin tick(); n++; end
    check({tag, " resValid"}, W'(bus.outResValid), W'(1'b1));
    res = bus.outRes;
    bus.inResReady = 1'b1;
    tick();
    bus.inResReady = 1'b0;
    check({tag, " resDone"}, W'(bus.outResValid), '0);
  endtask

  initial begin
    logic [W-1:0] r, c0, c1, c2, e1, e2;
    int n, seen;

    inReset = 1'b1; inCfgCbc = 1'b0; inCfgDecipher = 1'b0; inCfgIndirect = 1'b0;
    inKeyLoad = 1'b0; inIvLoad = 1'b0; inKey = '0; inIv = '0; stuckBusy = 1'b0;
    bus.inBlkValid = 1'b0; bus.inBlk = '0; bus.inResReady = 1'b0;
    tick(); tick();
    check("rst flags", W'({bus.outBlkReady, bus.outResValid, outCtrlBusy, outErr,
                           outCoreMode, outCoreDecipher, outCoreKeyWr, outCoreDataWr}), '0);
    check("rst res", bus.outRes, '0);
    inReset = 1'b0;
    tick();
    bus.inBlkValid = 1'b1; #1;
    check("no key ready", W'(bus.outBlkReady), '0);
    bus.inBlkValid = 1'b0;

    // 1/2: ECB direct encipher and decipher of the zero vector
    loadKey("t1", '0, 1'b0);
    runBlk("t1", '0, 1'b0, 1'b0, r);
    check("t1 ecb enc", r, V1);
    runBlk("t2", V1, 1'b0, 1'b1, r);
    check("t2 ecb dec", r, '0);

    // Request priority: key and IV loads mask block ready
    bus.inBlkValid = 1'b1; inKeyLoad = 1'b1; #1;
    check("prio key", W'(bus.outBlkReady), '0);
    inKeyLoad = 1'b0; inIvLoad = 1'b1; #1;
    check("prio iv", W'(bus.outBlkReady), '0);
    inIvLoad = 1'b0; #1;
    check("prio none", W'(bus.outBlkReady), W'(1'b1));
    bus.inBlkValid = 1'b0;

    // 3: indirect key mode
    loadKey("t3", '0, 1'b1);
    runBlk("t3", '0, 1'b0, 1'b0, r);
    check("t3 indirect", r, V3);

    // 6: reset while waiting on the core drops the block
    bus.inBlk = 128'h123; inCfgCbc = 1'b0; inCfgDecipher = 1'b1; bus.inBlkValid = 1'b1;
    #1;
    check("t6 accept", W'(bus.outBlkReady), W'(1'b1));
    tick();
    bus.inBlkValid = 1'b0;
    check("t6 dataWr", W'(outCoreDataWr), W'(1'b1));
    tick();
    check("t6 dataWrPulse", W'(outCoreDataWr), '0);
    inReset = 1'b1;
    tick();
    inReset = 1'b0;
    check("t6 flags", W'({bus.outBlkReady, bus.outResValid, outCtrlBusy, outErr,
                          outCoreMode, outCoreDecipher, outCoreKeyWr, outCoreDataWr}), '0);
    check("t6 res", bus.outRes, '0);
    check("t6 keyData", outCoreKeyData, '0);
    check("t6 data", outCoreDataData, '0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.outResValid) seen++;
      tick();
    end
    check("t6 no result", W'(seen), '0);
    loadKey("t6", '0, 1'b0);
    runBlk("t6 rerun", '0, 1'b0, 1'b0, r);
    check("t6 rerun", r, V1);

    // 4: CBC encipher of {0,1,2} with an ECB block in between, then CBC decipher
    e1 = coreFn('0, 1'b0, 1'b0, 128'd1 ^ V1);
    loadIv('0);
    runBlk("t4 e0", 128'd0, 1'b1, 1'b0, c0);
    check("t4 c0", c0, V1);
    runBlk("t4 ecb", 128'd5, 1'b0, 1'b0, r);
    check("t4 ecb mid", r, 128'h28);
    bus.inBlk = 128'd1; inCfgCbc = 1'b1; inCfgDecipher = 1'b0; bus.inBlkValid = 1'b1;
    #1;
    check("t4 e1 accept", W'(bus.outBlkReady), W'(1'b1));
    tick();
    check("t4 e1 xor", outCoreDataData, 128'd1 ^ V1);
    bus.inBlkValid = 1'b0;
    n = 0;
    while (!bus.outResValid && n < 200) begin tick(); n++; end
    c1 = bus.outRes;
    bus.inResReady = 1'b1; tick(); bus.inResReady = 1'b0;
    check("t4 c1", c1, e1);
    e2 = coreFn('0, 1'b0, 1'b0, 128'd2 ^ e1);
    runBlk("t4 e2", 128'd2, 1'b1, 1'b0, c2);
    check("t4 c2", c2, e2);
    loadIv('0);
    runBlk("t4 d0", c0, 1'b1, 1'b1, r);
    check("t4 p0", r, 128'd0);
    runBlk("t4 d1", c1, 1'b1, 1'b1, r);
    check("t4 p1", r, 128'd1);
    runBlk("t4 d2", c2, 1'b1, 1'b1, r);
    check("t4 p2", r, 128'd2);

    // 5: result held under backpressure
    bus.inBlk = '0; inCfgCbc = 1'b0; inCfgDecipher = 1'b0; bus.inBlkValid = 1'b1;
    #1;
    check("t5 accept", W'(bus.outBlkReady), W'(1'b1));
    tick();
    n = 0;
    while (!bus.outResValid && n < 200) begin tick(); n++; end
    for (int i = 0; i < 20; i++) tick();
    check("t5 hold valid", W'(bus.outResValid), W'(1'b1));
    check("t5 hold res", bus.outRes, V1);
    check("t5 hold ready", W'(bus.outBlkReady), '0);
    bus.inBlkValid = 1'b0;
    bus.inResReady = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.outResValid && bus.inResReady) seen++;
      tick();
    end
    bus.inResReady = 1'b0;
    check("t5 transfers", W'(seen), W'(1));

    // Timeout: core stuck busy
    stuckBusy = 1'b1;
    bus.inBlk = '0; inCfgCbc = 1'b0; inCfgDecipher = 1'b0; bus.inBlkValid = 1'b1;
    #1;
    check("tmo accept", W'(bus.outBlkReady), W'(1'b1));
    tick();
    bus.inBlkValid = 1'b0;
    n = 0; seen = 0;
    while (!outErr && n < 300) begin
      if (bus.outResValid) seen++;
      tick(); n++;
    end
    check("tmo err", W'(outErr), W'(1'b1));
    check("tmo cycles", W'(n), W'(65));
    check("tmo no result", W'(seen), '0);
    check("tmo idle", W'(outCtrlBusy), '0);
    bus.inBlkValid = 1'b1; #1;
    check("tmo key invalid", W'(bus.outBlkReady), '0);
    bus.inBlkValid = 1'b0;
    stuckBusy = 1'b0;
    tick(); tick();
    check("tmo err sticky", W'(outErr), W'(1'b1));
    loadKey("tmo", '0, 1'b0);
    runBlk("tmo rerun", '0, 1'b0, 1'b0, r);
    check("tmo rerun", r, V1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
